// File: rtl/galaga_lib.sv
// Shared game constants, scheduler state encoding and LFSR defaults.
// Latency: n/a (declarations only). Backpressure: n/a.
// Consumers: enemy_fire_scheduler and esched_lfsr.
package galaga_lib;

  localparam int NM  = 10;  // enemy ships on the board
  localparam int NPE = 3;   // enemy projectile slots

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIRE
  } esched_state_t;

  // Feedback mask for x^10 + x^7 + 1: taps on bits 9 and 6
  localparam logic [9:0] ESCHED_LFSR_TAPS = 10'h240;
  localparam logic [9:0] LFSR_SEED        = 10'h2A5;

endpackage

// File: rtl/esched_lfsr.sv
// 10-bit Fibonacci LFSR used to pick the first ship probed per fire attempt.
// Latency: new value every enabled frame. Backpressure: Enable low holds the value.
// The seed must be nonzero or the register stays locked at zero.
module esched_lfsr #(
  parameter logic [9:0] SEED = galaga_lib::LFSR_SEED
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Enable,
  output logic [9:0] Lfsr
);
  import galaga_lib::*;

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      Lfsr <= SEED;
    end else if (Enable) begin
      Lfsr <= {Lfsr[8:0], ^(Lfsr & ESCHED_LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Picks a live enemy ship once per fire period and pulses its one-hot fire request.
// Latency: pulse 2..NM+1 frames after the period wrap. No backpressure: an attempt
// without a free projectile slot is dropped. ESCHED_AGGRESSION_EN shortens the period as ships die.
module enemy_fire_scheduler #(
  parameter int         NM          = galaga_lib::NM,
  parameter int         FIRE_PERIOD = 48,
  parameter logic [9:0] LFSR_SEED   = galaga_lib::LFSR_SEED,
  parameter int         AGGR_STEP   = 3,
  parameter int         MIN_PERIOD  = 12
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          Enable,
  input  logic [NM-1:0] EShipAlive,
  input  logic          EProjAvail,
  output logic [NM-1:0] ESchedFire,
  output logic [9:0]    ESchedCtr,
  output logic [7:0]    ESchedShots
);
  import galaga_lib::*;

  localparam int IW = $clog2(NM);

  // The scan must finish before the next wrap can arrive
  if (NM < 2 || NM > 64) begin : gBadNm
    $error("enemy_fire_scheduler: NM must be within 2..64");
  end
  if (FIRE_PERIOD < NM + 3 || MIN_PERIOD < NM + 3) begin : gBadPeriod
    $error("enemy_fire_scheduler: periods must be at least NM+3");
  end
  if (AGGR_STEP < 0 || LFSR_SEED == 10'd0) begin : gBadCfg
    $error("enemy_fire_scheduler: AGGR_STEP negative or LFSR_SEED zero");
  end

  esched_state_t   state, nextState;
  logic [IW-1:0]   scanIdx, nextIdx, scanCnt, nextCnt, startIdx;
  logic [NM-1:0]   nextFire;
  logic [7:0]      nextShots;
  logic [9:0]      lfsr, periodQ, periodD;
  logic            wrap;

  esched_lfsr #(.SEED(LFSR_SEED)) uLfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .Lfsr      (lfsr)
  );

`ifdef ESCHED_AGGRESSION_EN
  logic [6:0] aliveCnt;
  int         aggrP;

  always_comb begin
    aliveCnt = '0;
    for (int i = 0; i < NM; i++) begin
      aliveCnt = aliveCnt + 7'(EShipAlive[i]);
    end
    aggrP   = FIRE_PERIOD - AGGR_STEP * (NM - int'(aliveCnt));
    periodD = (aggrP < MIN_PERIOD) ? 10'(MIN_PERIOD) : 10'(aggrP);
  end
`else
  assign periodD = 10'(FIRE_PERIOD);
`endif

  assign wrap     = (ESchedCtr >= periodQ - 10'd1);
  assign startIdx = IW'(lfsr % 10'(NM));

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      scanIdx     <= '0;
      scanCnt     <= '0;
      ESchedFire  <= '0;
      ESchedShots <= '0;
      ESchedCtr   <= '0;
      periodQ     <= 10'(FIRE_PERIOD);
    end else begin
      state       <= nextState;
      scanIdx     <= nextIdx;
      scanCnt     <= nextCnt;
      ESchedFire  <= nextFire;
      ESchedShots <= nextShots;
      if (Enable) begin
        if (wrap) begin
          ESchedCtr <= '0;
          periodQ   <= periodD;
        end else begin
          ESchedCtr <= ESchedCtr + 10'd1;
        end
      end
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = scanIdx;
    nextCnt   = scanCnt;
    nextFire  = '0;
    nextShots = ESchedShots;
    if (!Enable) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wrap && EProjAvail && |EShipAlive) begin
            nextState = SCAN;
            nextIdx   = startIdx;
            nextCnt   = '0;
          end
        end
        SCAN: begin
          if (EShipAlive[scanIdx]) begin
            nextFire[scanIdx] = 1'b1;
            nextState         = FIRE;
            if (ESchedShots != 8'hFF) nextShots = ESchedShots + 8'd1;
          end else begin
            nextIdx = (scanIdx == IW'(NM - 1)) ? '0 : scanIdx + 1'b1;
            // Every ship has been probed once with no hit
            if (scanCnt == IW'(NM - 1)) nextState = IDLE;
            else                        nextCnt   = scanCnt + 1'b1;
          end
        end
        FIRE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

endmodule
